mx_block_quant_ctrl: RTL and testbench

Block-level sequencer for MX quantisation. Collects one block of BLOCK_SIZE signed WIDTH_I elements and tracks the largest signed bit-length while filling. It then computes one shared shift (the block scale) and streams every element through a shift-and-round stage (round-to-nearest-even) to WIDTH_O bits, one per cycle. It sits between the fixed-point producer and the MX element packer.

---
 rtl/mx_block_quant_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mx_block_quant_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mx_block_quant_ctrl.sv
// -----------------------------------------------------------------------------
// mx_block_quant_ctrl
//
// Block-level sequencer for MX quantisation. Sits between the fixed-point
// producer and the MX element packer.
//
//   FILL  : accepts BLOCK_SIZE signed WIDTH_I elements into a local buffer and
//           tracks the largest signed bit-length n seen so far.
//   SCALE : one cycle; derives the shared block shift T = max(n - WIDTH_O, 0).
//   EMIT  : streams every buffered element through an arithmetic right shift
//           by T with round-to-nearest-even, one element per cycle, under a
//           valid/ready handshake. Returns to FILL after the last handshake.
//
// Optional feature (compile-time macro SHIFT_RND_SAT_EN):
//   defined   : a rounded value above the positive limit saturates to
//               2^(WIDTH_O-1)-1; o_ofl still flags it.
//   undefined : o_elem carries the wrapped WIDTH_O-bit result; o_ofl flags it.
//
// Ports:
//   i_clk    in   1            clock
//   i_rst    in   1            asynchronous reset, active-high
//   i_num    in   WIDTH_I      signed input element
//   i_valid  in   1            input element valid
//   o_ready  out  1            block accepts an input element (FILL only)
//   o_elem   out  WIDTH_O      rounded signed output element
//   o_scale  out  WIDTH_SHIFT  block shift T, constant for the whole block
//   o_last   out  1            marks the final element of the block
//   o_ofl    out  1            rounding overflowed for this element
//   o_valid  out  1            output element valid
//   i_ready  in   1            downstream accepts output
// -----------------------------------------------------------------------------
module mx_block_quant_ctrl #(
  parameter int BLOCK_SIZE  = 32,
  parameter int WIDTH_I     = 9,
  parameter int WIDTH_O     = 8,
  parameter int WIDTH_SHIFT = $clog2(WIDTH_I + 2),
  parameter int WIDTH_CNT   = $clog2(BLOCK_SIZE)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [WIDTH_I-1:0]   i_num,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [WIDTH_O-1:0]   o_elem,
  output logic        [WIDTH_SHIFT-1:0] o_scale,
  output logic                        o_last,
  output logic                        o_ofl,
  output logic                        o_valid,
  input  logic                        i_ready
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SCALE = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  localparam logic [WIDTH_CNT-1:0]   LAST_IDX = WIDTH_CNT'(BLOCK_SIZE - 1);
  localparam logic [WIDTH_SHIFT-1:0] WO_S     = WIDTH_SHIFT'(WIDTH_O);
  localparam logic [WIDTH_SHIFT-1:0] N_INIT   = WIDTH_SHIFT'(1);

  // Largest positive output value, widened to the rounding result width.
  localparam logic signed [WIDTH_I:0] MAX_POS_W =
    {{(WIDTH_I - WIDTH_O + 2){1'b0}}, {(WIDTH_O - 1){1'b1}}};
  localparam logic signed [WIDTH_O-1:0] MAX_POS_O = {1'b0, {(WIDTH_O - 1){1'b1}}};

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [WIDTH_CNT-1:0]       cnt_q, cnt_d;       // fill index / emit index
  logic [WIDTH_SHIFT-1:0]     nmax_q, nmax_d;     // running max bit-length
  logic [WIDTH_SHIFT-1:0]     scale_q, scale_d;   // block shift T
  logic signed [WIDTH_O-1:0]  elem_q, elem_d;
  logic                       ofl_q, ofl_d;
  logic                       last_q, last_d;
  logic                       valid_q, valid_d;

  logic signed [WIDTH_I-1:0]  buf_q [BLOCK_SIZE];

  logic accept;
  logic handshake;

  assign o_ready   = (state_q == ST_FILL) && !i_rst;
  assign accept    = o_ready && i_valid;
  assign handshake = valid_q && i_ready;

  // ---------------------------------------------------------------------------
  // Bit-length of the incoming element. For negative x, bitlen(x) equals
  // bitlen(~x), so fold onto the non-negative side and find the top set bit.
  // ---------------------------------------------------------------------------
  logic [WIDTH_I-1:0]     in_mag;
  logic [WIDTH_SHIFT-1:0] in_bitlen;

  always_comb begin
    in_mag    = i_num[WIDTH_I-1] ? ~i_num : i_num;
    in_bitlen = N_INIT;
    for (int i = 0; i < WIDTH_I; i++) begin
      if (in_mag[i]) in_bitlen = WIDTH_SHIFT'(i + 2);
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-and-round of the element at the current emit index.
  //   G = bit T-1, R = bit T-2, S = OR of bits below T-2.
  //   Round up when G & (R | S | LSB of shifted value) -> ties to even.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH_I-1:0] sel_elem;
  logic signed [WIDTH_I-1:0] shifted;
  logic                      g_bit, r_bit, s_bit, rnd_up;
  logic signed [WIDTH_I:0]   rounded;
  logic                      rnd_ofl;
  logic signed [WIDTH_O-1:0] rnd_elem;

  always_comb begin
    sel_elem = buf_q[cnt_q];
    shifted  = sel_elem >>> scale_q;
    g_bit    = 1'b0;
    r_bit    = 1'b0;
    s_bit    = 1'b0;
    for (int i = 0; i < WIDTH_I; i++) begin
      if (i + 1 == int'(scale_q)) g_bit = sel_elem[i];
      if (i + 2 == int'(scale_q)) r_bit = sel_elem[i];
      if (i + 2 <  int'(scale_q)) s_bit = s_bit | sel_elem[i];
    end
    rnd_up  = g_bit & (r_bit | s_bit | shifted[0]);
    rounded = {shifted[WIDTH_I-1], shifted} + {{WIDTH_I{1'b0}}, rnd_up};
    // Rounding only ever moves upward, so only the positive limit can be crossed.
    rnd_ofl = (rounded > MAX_POS_W);
`ifdef SHIFT_RND_SAT_EN
    rnd_elem = rnd_ofl ? MAX_POS_O : rounded[WIDTH_O-1:0];
`else
    rnd_elem = rounded[WIDTH_O-1:0];
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nmax_d  = nmax_q;
    scale_d = scale_q;
    elem_d  = elem_q;
    ofl_d   = ofl_q;
    last_d  = last_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          cnt_d = cnt_q + WIDTH_CNT'(1);
          if (in_bitlen > nmax_q) nmax_d = in_bitlen;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_SCALE;
          end
        end
      end

      ST_SCALE: begin
        scale_d = (nmax_q > WO_S) ? (nmax_q - WO_S) : '0;
        cnt_d   = '0;
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        if (handshake && last_q) begin
          // Final element consumed: back to collecting a fresh block.
          valid_d = 1'b0;
          last_d  = 1'b0;
          ofl_d   = 1'b0;
          nmax_d  = N_INIT;
          cnt_d   = '0;
          state_d = ST_FILL;
        end else if (!valid_q || i_ready) begin
          // Output register empty or being drained: load the next element.
          // Once the last element is loaded and stalled, this branch is not
          // taken because valid_q && !i_ready.
          elem_d  = rnd_elem;
          ofl_d   = rnd_ofl;
          last_d  = (cnt_q == LAST_IDX);
          valid_d = 1'b1;
          cnt_d   = cnt_q + WIDTH_CNT'(1);
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      nmax_q  <= N_INIT;
      scale_q <= '0;
      elem_q  <= '0;
      ofl_q   <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      nmax_q  <= nmax_d;
      scale_q <= scale_d;
      elem_q  <= elem_d;
      ofl_q   <= ofl_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the element buffer is deliberately not reset; its contents are only
  // read after a full block has been written, and skipping the reset keeps it
  // mappable to plain storage.
  always_ff @(posedge i_clk) begin
    if (accept) buf_q[cnt_q] <= i_num;
  end

  assign o_elem  = elem_q;
  assign o_scale = scale_q;
  assign o_last  = last_q;
  assign o_ofl   = ofl_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mx_block_quant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mx_block_quant_ctrl
//
// Directed bench for mx_block_quant_ctrl with BLOCK_SIZE=4, WIDTH_I=9,
// WIDTH_O=8. A table of whole blocks with hand-computed outputs is applied
// back to back, followed by hand-written stall and mid-block reset sequences.
// -----------------------------------------------------------------------------
module tb_mx_block_quant_ctrl;

  localparam int BS = 4;
  localparam int WI = 9;
  localparam int WO = 8;
  localparam int WS = $clog2(WI + 2);
  localparam int WC = $clog2(BS);

`ifdef SHIFT_RND_SAT_EN
  localparam int OFL_VAL = 127;
`else
  localparam int OFL_VAL = -128;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [WI-1:0] num;
  logic                 vld_in;
  logic                 rdy_out;
  logic signed [WO-1:0] elem;
  logic [WS-1:0]        scale;
  logic                 last;
  logic                 ofl;
  logic                 vld_out;
  logic                 rdy_in;

  always #5 clk = ~clk;

  mx_block_quant_ctrl #(
    .BLOCK_SIZE (BS),
    .WIDTH_I    (WI),
    .WIDTH_O    (WO),
    .WIDTH_SHIFT(WS),
    .WIDTH_CNT  (WC)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_num  (num),
    .i_valid(vld_in),
    .o_ready(rdy_out),
    .o_elem (elem),
    .o_scale(scale),
    .o_last (last),
    .o_ofl  (ofl),
    .o_valid(vld_out),
    .i_ready(rdy_in)
  );

  typedef struct packed {
    logic [BS-1:0][WI-1:0] num;
    logic [BS-1:0][WO-1:0] elem;
    logic [BS-1:0]         ofl;
    logic [WS-1:0]         scale;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int n0, input int n1, input int n2, input int n3,
                              input int e0, input int e1, input int e2, input int e3,
                              input logic [BS-1:0] of, input int t);
    vec_t v;
    v.num[0]  = WI'(n0);
    v.num[1]  = WI'(n1);
    v.num[2]  = WI'(n2);
    v.num[3]  = WI'(n3);
    v.elem[0] = WO'(e0);
    v.elem[1] = WO'(e1);
    v.elem[2] = WO'(e2);
    v.elem[3] = WO'(e3);
    v.ofl     = of;
    v.scale   = WS'(t);
    return v;
  endfunction

  // Pushes one block and checks the two-cycle gap before the first output.
  task automatic send_block(input logic [BS-1:0][WI-1:0] nums, input string tag);
    for (int k = 0; k < BS; k++) begin
      num    = nums[k];
      vld_in = 1'b1;
      check($sformatf("%s in%0d o_ready", tag, k), rdy_out, 1);
      tick();
    end
    vld_in = 1'b0;
    num    = '0;
    check($sformatf("%s scale-cycle o_valid", tag), vld_out, 0);
    check($sformatf("%s scale-cycle o_ready", tag), rdy_out, 0);
    tick();
    check($sformatf("%s gap o_valid", tag), vld_out, 0);
    tick();
    check($sformatf("%s first o_valid", tag), vld_out, 1);
  endtask

  // Checks the currently presented element, then advances one cycle.
  task automatic expect_out(input int e, input bit o, input bit l, input int t,
                            input string tag);
    check($sformatf("%s o_valid", tag), vld_out, 1);
    check($sformatf("%s o_elem", tag), elem, e);
    check($sformatf("%s o_ofl", tag), ofl, o);
    check($sformatf("%s o_last", tag), last, l);
    check($sformatf("%s o_scale", tag), scale, t);
    check($sformatf("%s o_ready", tag), rdy_out, 0);
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    rdy_in = 1'b1;
    send_block(v.num, tag);
    for (int k = 0; k < BS; k++) begin
      expect_out(int'($signed(v.elem[k])), v.ofl[k], (k == BS - 1), int'(v.scale),
                 $sformatf("%s out%0d", tag, k));
    end
    check($sformatf("%s end o_valid", tag), vld_out, 0);
    check($sformatf("%s end o_ready", tag), rdy_out, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = mk(200, 3, -5, 1,      100, 2, -2, 0,       4'b0000, 1);
    vecs[1] = mk(255, 0, 0, 0,       OFL_VAL, 0, 0, 0,    4'b0001, 1);
    vecs[2] = mk(100, -128, 0, 7,    100, -128, 0, 7,     4'b0000, 0);
    vecs[3] = mk(0, 0, 0, 0,         0, 0, 0, 0,          4'b0000, 0);
    vecs[4] = mk(-256, 6, -6, 2,     -128, 3, -3, 1,      4'b0000, 1);

    rst    = 1'b1;
    num    = '0;
    vld_in = 1'b0;
    rdy_in = 1'b0;
    #2;
    check("reset o_ready", rdy_out, 0);
    check("reset o_valid", vld_out, 0);
    check("reset o_elem", elem, 0);
    check("reset o_scale", scale, 0);
    check("reset o_last", last, 0);
    check("reset o_ofl", ofl, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post-reset o_ready", rdy_out, 1);

    // Table-driven whole blocks, back to back.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Downstream stall after the second output; i_valid noise must be ignored.
    rdy_in = 1'b1;
    send_block(vecs[0].num, "stall");
    expect_out(100, 0, 0, 1, "stall out0");
    expect_out(2, 0, 0, 1, "stall out1");
    rdy_in = 1'b0;
    vld_in = 1'b1;
    num    = -9'sd200;
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall hold%0d o_valid", s), vld_out, 1);
      check($sformatf("stall hold%0d o_elem", s), elem, -2);
      check($sformatf("stall hold%0d o_last", s), last, 0);
      check($sformatf("stall hold%0d o_scale", s), scale, 1);
      check($sformatf("stall hold%0d o_ready", s), rdy_out, 0);
    end
    vld_in = 1'b0;
    num    = '0;
    rdy_in = 1'b1;
    expect_out(-2, 0, 0, 1, "stall out2");
    expect_out(0, 0, 1, 1, "stall out3");
    check("stall end o_valid", vld_out, 0);
    check("stall end o_ready", rdy_out, 1);

    // Reset in the middle of EMIT discards the block.
    send_block(vecs[2].num, "rstmid");
    expect_out(100, 0, 0, 0, "rstmid out0");
    expect_out(-128, 0, 0, 0, "rstmid out1");
    #2;
    rst = 1'b1;
    #1;
    check("rstmid o_valid", vld_out, 0);
    check("rstmid o_elem", elem, 0);
    check("rstmid o_last", last, 0);
    check("rstmid o_scale", scale, 0);
    check("rstmid o_ofl", ofl, 0);
    check("rstmid o_ready", rdy_out, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid released o_ready", rdy_out, 1);
    run_vec(mk(4, 4, 4, 4, 4, 4, 4, 4, 4'b0000, 0), "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
